// File: rtl/ram_arbiter_pkg.sv
// Shared cache-subsystem definitions (package cache_pkg): arbiter state encoding,
// requester port identifiers and default bus widths.
package cache_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic PORT_ICACHE = 1'b0;
  localparam logic PORT_DCACHE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the two cache-controller request ports and the single backing-RAM port.
// "master" is the environment side (caches + RAM), "slave" is the arbiter.
interface ram_arbiter_if
  import cache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req0_avalid;
  logic              req0_wr;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ack;

  logic              req1_avalid;
  logic              req1_wr;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ack;

  logic [DATA_W-1:0] req_rdata;

  logic              ram_avalid;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;

  modport master (
    output req0_avalid, req0_wr, req0_addr, req0_wdata,
    output req1_avalid, req1_wr, req1_addr, req1_wdata,
    output ram_rdata, ram_ack,
    input  req0_ack, req1_ack, req_rdata,
    input  ram_avalid, ram_wr, ram_addr, ram_wdata
  );

  modport slave (
    input  req0_avalid, req0_wr, req0_addr, req0_wdata,
    input  req1_avalid, req1_wr, req1_addr, req1_wdata,
    input  ram_rdata, ram_ack,
    output req0_ack, req1_ack, req_rdata,
    output ram_avalid, ram_wr, ram_addr, ram_wdata
  );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the port that did not win last
// time is chosen, otherwise the single requester wins.
module rr_arb2
  import cache_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_valid_o,
  output logic grant_idx_o
);

  always_comb begin
    grant_valid_o = req0_i | req1_i;
    grant_idx_o   = PORT_ICACHE;
    if (req0_i && req1_i) begin
      grant_idx_o = ~last_grant_i;
    end else if (req1_i) begin
      grant_idx_o = PORT_DCACHE;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one backing-RAM port between the I-cache (port 0) and D-cache (port 1)
// with round-robin grants held per transaction. Optional RAM_ARB_TIMEOUT_EN adds an ack watchdog.
module ram_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
`ifdef RAM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic clk,
  input  logic not_reset,
  ram_arbiter_if.slave bus
`ifdef RAM_ARB_TIMEOUT_EN
  ,
  output logic timeout_err
`endif
);

  arb_state_e        state_q, state_d;
  logic              lastGrant_q, lastGrant_d;
  logic              ramAvalid_q, ramAvalid_d;
  logic              ramWr_q, ramWr_d;
  logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;
  logic [DATA_W-1:0] ramWdata_q, ramWdata_d;
  logic [DATA_W-1:0] reqRdata_q, reqRdata_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              grantValid;
  logic              grantIdx;

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int              CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] tmoCnt_q, tmoCnt_d;
  logic             tmoErr_q, tmoErr_d;
`endif

  rr_arb2 u_pick (
    .req0_i        (bus.req0_avalid),
    .req1_i        (bus.req1_avalid),
    .last_grant_i  (lastGrant_q),
    .grant_valid_o (grantValid),
    .grant_idx_o   (grantIdx)
  );

  // While a grant is held, lastGrant_q doubles as the index of the port being served.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    ramAvalid_d = ramAvalid_q;
    ramWr_d     = ramWr_q;
    ramAddr_d   = ramAddr_q;
    ramWdata_d  = ramWdata_q;
    reqRdata_d  = reqRdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
    tmoCnt_d    = tmoCnt_q;
    tmoErr_d    = tmoErr_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (grantValid) begin
          state_d     = GRANT;
          lastGrant_d = grantIdx;
          ramAvalid_d = 1'b1;
          if (grantIdx == PORT_DCACHE) begin
            ramWr_d    = bus.req1_wr;
            ramAddr_d  = bus.req1_addr;
            ramWdata_d = bus.req1_wdata;
          end else begin
            ramWr_d    = bus.req0_wr;
            ramAddr_d  = bus.req0_addr;
            ramWdata_d = bus.req0_wdata;
          end
`ifdef RAM_ARB_TIMEOUT_EN
          tmoCnt_d = '0;
`endif
        end
      end

      GRANT: begin
        if (bus.ram_ack) begin
          state_d     = RESP;
          ramAvalid_d = 1'b0;
          ramWr_d     = 1'b0;
          reqRdata_d  = bus.ram_rdata;
          ack0_d      = (lastGrant_q == PORT_ICACHE);
          ack1_d      = (lastGrant_q == PORT_DCACHE);
        end
`ifdef RAM_ARB_TIMEOUT_EN
        else if (tmoCnt_q == CNT_LIMIT - 1'b1) begin
          // The RAM never answered: complete the request with zero data and flag it.
          state_d     = RESP;
          ramAvalid_d = 1'b0;
          ramWr_d     = 1'b0;
          reqRdata_d  = '0;
          ack0_d      = (lastGrant_q == PORT_ICACHE);
          ack1_d      = (lastGrant_q == PORT_DCACHE);
          tmoCnt_d    = CNT_LIMIT;
          tmoErr_d    = 1'b1;
        end else begin
          tmoCnt_d = tmoCnt_q + 1'b1;
        end
`endif
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state_q     <= IDLE;
      lastGrant_q <= PORT_DCACHE;
      ramAvalid_q <= 1'b0;
      ramWr_q     <= 1'b0;
      ramAddr_q   <= '0;
      ramWdata_q  <= '0;
      reqRdata_q  <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
      tmoCnt_q    <= '0;
      tmoErr_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      ramAvalid_q <= ramAvalid_d;
      ramWr_q     <= ramWr_d;
      ramAddr_q   <= ramAddr_d;
      ramWdata_q  <= ramWdata_d;
      reqRdata_q  <= reqRdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
`ifdef RAM_ARB_TIMEOUT_EN
      tmoCnt_q    <= tmoCnt_d;
      tmoErr_q    <= tmoErr_d;
`endif
    end
  end

  assign bus.ram_avalid = ramAvalid_q;
  assign bus.ram_wr     = ramWr_q;
  assign bus.ram_addr   = ramAddr_q;
  assign bus.ram_wdata  = ramWdata_q;
  assign bus.req_rdata  = reqRdata_q;
  assign bus.req0_ack   = ack0_q;
  assign bus.req1_ack   = ack1_q;
`ifdef RAM_ARB_TIMEOUT_EN
  assign timeout_err    = tmoErr_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic checked against a
// request-level model (pending requests, last winner, RAM contents). Covers RAM_ARB_TIMEOUT_EN when defined.
module tb_ram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic not_reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int TMO = 8;
  logic timeoutErr;
  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .not_reset(not_reset), .bus(bus), .timeout_err(timeoutErr));
`else
  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .not_reset(not_reset), .bus(bus));
`endif

  always #5 clk = ~clk;

  // Request-level model: what each cache wants, who won last, and what the RAM holds.
  bit          pend [2];
  logic        rqWr [2];
  logic [31:0] rqAddr [2];
  logic [31:0] rqWdata [2];
  bit          prevPort;
  logic [31:0] mem [logic [31:0]];
  int          grantLog [$];

  function automatic logic [31:0] ramRead(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    bus.req0_avalid = pend[0];
    bus.req0_wr     = rqWr[0];
    bus.req0_addr   = rqAddr[0];
    bus.req0_wdata  = rqWdata[0];
    bus.req1_avalid = pend[1];
    bus.req1_wr     = rqWr[1];
    bus.req1_addr   = rqAddr[1];
    bus.req1_wdata  = rqWdata[1];
  endtask

  task automatic request(input int p, input logic wr, input logic [31:0] a, input logic [31:0] d);
    pend[p]    = 1'b1;
    rqWr[p]    = wr;
    rqAddr[p]  = a;
    rqWdata[p] = d;
  endtask

  task automatic randomRequest(input int p);
    request(p, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
  endtask

  // Called on a falling edge right after the requests have been driven. The grant happens
  // on the next rising edge; the RAM answers after 'latency' GRANT cycles.
  task automatic serveNext(input int latency, input bit perturb);
    int          w;
    logic        expWr;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [31:0] rd;
    if (pend[0] && pend[1]) w = prevPort ? 0 : 1;
    else                    w = pend[1] ? 1 : 0;
    expWr    = rqWr[w];
    expAddr  = rqAddr[w];
    expWdata = rqWdata[w];

    @(negedge clk);
    checkOutput("grant_avalid", 32'(bus.ram_avalid), 1);
    checkOutput("grant_wr", 32'(bus.ram_wr), 32'(expWr));
    checkOutput("grant_addr", bus.ram_addr, expAddr);
    checkOutput("grant_wdata", bus.ram_wdata, expWdata);
    checkOutput("grant_no_ack", 32'({bus.req1_ack, bus.req0_ack}), 0);

    for (int i = 1; i < latency; i++) begin
      if (perturb) begin
        bus.req0_addr  = $urandom;
        bus.req0_wdata = $urandom;
        bus.req1_addr  = $urandom;
        bus.req1_wdata = $urandom;
        bus.req1_wr    = ~bus.req1_wr;
      end
      @(negedge clk);
      checkOutput("hold_avalid", 32'(bus.ram_avalid), 1);
      checkOutput("hold_addr", bus.ram_addr, expAddr);
      checkOutput("hold_wdata", bus.ram_wdata, expWdata);
      checkOutput("hold_wr", 32'(bus.ram_wr), 32'(expWr));
      checkOutput("hold_no_ack", 32'({bus.req1_ack, bus.req0_ack}), 0);
    end

    if (expWr) begin
      mem[expAddr] = expWdata;
      rd = $urandom;
    end else begin
      rd = ramRead(expAddr);
    end
    bus.ram_rdata = rd;
    bus.ram_ack   = 1'b1;
    @(negedge clk);
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = $urandom;
    checkOutput("ack_winner", 32'(w == 1 ? bus.req1_ack : bus.req0_ack), 1);
    checkOutput("ack_other", 32'(w == 1 ? bus.req0_ack : bus.req1_ack), 0);
    checkOutput("ack_avalid_drop", 32'(bus.ram_avalid), 0);
    checkOutput("ack_wr_drop", 32'(bus.ram_wr), 0);
    if (!expWr) checkOutput("read_data", bus.req_rdata, rd);

    prevPort = (w == 1);
    pend[w]  = 1'b0;
    grantLog.push_back(w);
    applyStimulus();
    @(negedge clk);
    checkOutput("ack_one_cycle", 32'({bus.req1_ack, bus.req0_ack}), 0);
  endtask

  initial begin
    int base;
    int cnt;
    pend[0] = 1'b0; pend[1] = 1'b0;
    rqWr[0] = 1'b0; rqWr[1] = 1'b0;
    rqAddr[0] = '0; rqAddr[1] = '0;
    rqWdata[0] = '0; rqWdata[1] = '0;
    prevPort = 1'b1;
    applyStimulus();
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_avalid", 32'(bus.ram_avalid), 0);
    checkOutput("rst_wr", 32'(bus.ram_wr), 0);
    checkOutput("rst_addr", bus.ram_addr, 0);
    checkOutput("rst_wdata", bus.ram_wdata, 0);
    checkOutput("rst_rdata", bus.req_rdata, 0);
    checkOutput("rst_acks", 32'({bus.req1_ack, bus.req0_ack}), 0);
`ifdef RAM_ARB_TIMEOUT_EN
    checkOutput("rst_timeout_err", 32'(timeoutErr), 0);
`endif
    not_reset = 1'b1;
    @(negedge clk);

    $display("[TB] port 0 read, RAM answers after 3 cycles");
    mem[32'h100] = 32'hDEAD_BEEF;
    request(0, 1'b0, 32'h100, 32'h0);
    applyStimulus();
    serveNext(3, 1'b0);
    checkOutput("t1_port", grantLog[$], 0);
    checkOutput("t1_rdata", bus.req_rdata, 32'hDEAD_BEEF);

    $display("[TB] port 1 write with inputs changing during GRANT");
    request(1, 1'b1, 32'h44, 32'hCAFE_0001);
    applyStimulus();
    serveNext(4, 1'b1);

    $display("[TB] simultaneous requests");
    request(0, 1'b1, 32'h200, 32'h11);
    request(1, 1'b0, 32'h300, 32'h0);
    applyStimulus();
    serveNext(2, 1'b0);
    serveNext(1, 1'b0);
    checkOutput("t2_first", grantLog[$-1], 0);
    checkOutput("t2_second", grantLog[$], 1);

    $display("[TB] continuous contention");
    base = grantLog.size();
    for (int k = 0; k < 6; k++) begin
      if (!pend[0]) randomRequest(0);
      if (!pend[1]) randomRequest(1);
      applyStimulus();
      serveNext(int'($urandom_range(1, 3)), 1'b0);
    end
    for (int k = 0; k < 6; k++) checkOutput("t3_alternate", grantLog[base + k], k % 2);
    serveNext(1, 1'b0);

    $display("[TB] reset during GRANT");
    request(1, 1'b1, 32'h80, 32'h77);
    applyStimulus();
    @(negedge clk);
    checkOutput("t5_granted", 32'(bus.ram_avalid), 1);
    checkOutput("t5_granted_wr", 32'(bus.ram_wr), 1);
    @(negedge clk);
    #2 not_reset = 1'b0;
    #1;
    checkOutput("t5_avalid", 32'(bus.ram_avalid), 0);
    checkOutput("t5_wr", 32'(bus.ram_wr), 0);
    checkOutput("t5_addr", bus.ram_addr, 0);
    checkOutput("t5_wdata", bus.ram_wdata, 0);
    checkOutput("t5_rdata", bus.req_rdata, 0);
    checkOutput("t5_acks", 32'({bus.req1_ack, bus.req0_ack}), 0);
    pend[1]  = 1'b0;
    prevPort = 1'b1;
    applyStimulus();
    @(negedge clk);
    @(negedge clk);
    not_reset = 1'b1;
    @(negedge clk);
    checkOutput("t5_no_late_ack", 32'({bus.req1_ack, bus.req0_ack}), 0);
    checkOutput("t5_idle", 32'(bus.ram_avalid), 0);
    request(1, 1'b0, 32'h80, 32'h0);
    applyStimulus();
    serveNext(2, 1'b0);
    request(0, 1'b0, 32'h8, 32'h0);
    request(1, 1'b1, 32'hC, 32'h1234);
    applyStimulus();
    serveNext(1, 1'b0);
    checkOutput("t5_tie_port0", grantLog[$], 0);
    serveNext(2, 1'b0);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 40; k++) begin
      if (!pend[0] && $urandom_range(0, 9) < 6) randomRequest(0);
      if (!pend[1] && $urandom_range(0, 9) < 6) randomRequest(1);
      if (!pend[0] && !pend[1]) randomRequest(int'($urandom_range(0, 1)));
      applyStimulus();
      serveNext(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
    end
    while (pend[0] || pend[1]) serveNext(1, 1'b0);

`ifdef RAM_ARB_TIMEOUT_EN
    $display("[TB] RAM never answers");
    checkOutput("tmo_err_clear", 32'(timeoutErr), 0);
    request(0, 1'b0, 32'h1F0, 32'h0);
    applyStimulus();
    @(negedge clk);
    checkOutput("tmo_granted", 32'(bus.ram_avalid), 1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.req0_ack && cnt < 20);
    checkOutput("tmo_latency", cnt, TMO);
    checkOutput("tmo_ack", 32'(bus.req0_ack), 1);
    checkOutput("tmo_other_ack", 32'(bus.req1_ack), 0);
    checkOutput("tmo_rdata", bus.req_rdata, 0);
    checkOutput("tmo_avalid_drop", 32'(bus.ram_avalid), 0);
    checkOutput("tmo_err_set", 32'(timeoutErr), 1);
    pend[0]  = 1'b0;
    prevPort = 1'b0;
    applyStimulus();
    @(negedge clk);
    request(1, 1'b0, 32'h24, 32'h0);
    applyStimulus();
    serveNext(2, 1'b0);
    checkOutput("tmo_err_sticky", 32'(timeoutErr), 1);
`else
    cnt = 0;
    base = cnt;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single backing-RAM port between two cache control units: port 0 is the instruction cache and port 1 is the data cache.
- Each requester uses the same avalid/wr/ack handshake that the cache controllers already drive toward RAM.
- Arbitration is round-robin. A grant is held for the whole RAM transaction and the response is routed back to the granted requester.
- Sits between the cache controllers and the RAM model/controller.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width of one RAM transfer
TIMEOUT, 255, max cycles waiting for ram_ack (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
not_reset  in  1  asynchronous active-low reset
req0_avalid  in  1  port 0 request valid, held until req0_ack
req0_wr  in  1  port 0: 1 = write, 0 = read
req0_addr  in  ADDR_W  port 0 address
req0_wdata  in  DATA_W  port 0 write data
req0_ack  out  1  port 0 completion pulse
req1_avalid  in  1  port 1 request valid, held until req1_ack
req1_wr  in  1  port 1: 1 = write, 0 = read
req1_addr  in  ADDR_W  port 1 address
req1_wdata  in  DATA_W  port 1 write data
req1_ack  out  1  port 1 completion pulse
req_rdata  out  DATA_W  read data, shared by both ports, valid only with reqN_ack
ram_avalid  out  1  RAM request valid
ram_wr  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid with ram_ack
ram_ack  in  1  RAM completion, single cycle

Behaviour:
- Reset (not_reset low, asynchronous):
  - state = IDLE, last_grant = 1, so port 0 wins the first tie.
  - All outputs are 0.
  - Any RAM transaction in flight is abandoned; no ack is issued for it.
- Registered FSM with states IDLE, GRANT, RESP. All outputs are registered.
- IDLE:
  - With no request, stay in IDLE.
  - With exactly one reqN_avalid, grant port N.
  - With both requesting, grant !last_grant.
  - On grant, at the same edge:
    - latch grant into last_grant;
    - latch the granted port's addr/wr/wdata into ram_addr/ram_wr/ram_wdata;
    - set ram_avalid = 1;
    - go to GRANT.
- GRANT:
  - ram_avalid, ram_addr, ram_wr and ram_wdata are held stable.
  - Requester inputs are ignored, including the granted requester's inputs.
  - On ram_ack = 1:
    - clear ram_avalid and ram_wr;
    - capture ram_rdata into req_rdata (writes also capture it, value don't-care);
    - pulse the granted reqN_ack for exactly one cycle;
    - go to RESP.
- RESP: reqN_ack is high this cycle. At the next edge, clear ack and go to IDLE.
- Requester contract:
  - reqN_avalid is deasserted in the cycle after it samples ack.
  - Because RESP → IDLE costs one cycle, a completed request is never re-granted.
  - A port requesting again is served after the other port if the other port is waiting. This gives strict alternation under contention.
- Latency:
  - Request sampled at edge E0; ram_avalid is high after E0.
  - ram_ack sampled at edge Ek; reqN_ack is high after Ek for one cycle.
  - Minimum request-to-ack is 2 edges.
- reqN_ack is never asserted for the non-granted port, and the two acks are never high together.
- A request that drops before grant is simply not served (protocol violation, no error).

Optional Feature:
- Macro: RAM_ARB_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entering GRANT and increments each GRANT cycle without ram_ack.
  - When it reaches TIMEOUT, drop ram_avalid, pulse the granted reqN_ack with req_rdata = 0, and go to RESP.
  - A sticky output `timeout_err` (1 bit) is set; only reset clears it.
- When undefined: no counter and no timeout_err port; GRANT waits indefinitely for ram_ack.

Decomposition:
- Shared package `cache_pkg`:
  - arbiter state encoding (IDLE=0, GRANT=1, RESP=2);
  - port index constants PORT_ICACHE=0, PORT_DCACHE=1;
  - default ADDR_W/DATA_W.
- One natural sub-module: `rr_arb2`, a combinational 2-way round-robin pick (req0, req1, last_grant → grant_valid, grant_idx).
- FSM, latching and routing stay in ram_arbiter.

Test Plan:
- Port 0 read only, addr 0x100, RAM acks 3 cycles after ram_avalid with 0xDEADBEEF → ram_addr = 0x100, ram_wr = 0; req0_ack pulses once with req_rdata = 0xDEADBEEF; req1_ack stays 0.
- Both ports request in the same cycle, port 0 write 0x200/0x11, port 1 read 0x300 → port 0 is served first (ram_wr = 1, ram_wdata = 0x11), then port 1; exactly one ack each, in order 0 then 1.
- Both ports hold requests continuously for 6 transactions, each re-asserting the cycle after ack → grants alternate 0,1,0,1,0,1.
- Port 1 changes addr/wdata while in GRANT → ram_addr/ram_wdata keep the values latched at grant until ram_ack.
- not_reset pulled low mid-GRANT, ram_ack never given → all outputs 0 immediately, no ack; after release a new port 1 request is served normally, and port 0 wins the next tie.
- With RAM_ARB_TIMEOUT_EN, TIMEOUT = 8, no ram_ack → ack 8 GRANT cycles after grant, req_rdata = 0, timeout_err = 1 and sticky.
